// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage: in-order inst_sram requests, in-flight PC queue and DEPTH-entry
// instruction buffer feeding ID. Optional same-cycle bypass when `IF_BYPASS_EN is defined.
module if_prefetch_queue #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter logic [31:0] PC_INIT         = 32'h1c000000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] pc_vaddr,
  input  logic [31:0] pc_trans,
  input  logic        except_tlbr,
  input  logic        except_pif,
  input  logic        except_ppi,
  output logic        inst_sram_en,
  output logic [31:0] inst_sram_addr,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst,
  input  logic        flush,
  input  logic [31:0] flush_target,
  input  logic        ID_flush,
  input  logic [31:0] ID_flush_target,
  input  logic        ID_allowin,
  output logic        IF_to_ID,
  output logic [65:0] IF_to_ID_zip,
  output logic [3:0]  IF_except_zip
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned OW = $clog2(DEPTH + 1);

  typedef enum logic {
    ST_RUN,
    ST_HALT
  } fetch_state_t;

  fetch_state_t state, state_nxt;

  logic [31:0]   pc_q;
  logic [CW-1:0] out_cnt, disc_cnt, disc_flush;
  logic [OW-1:0] occ;
  logic [PW-1:0] rd_ptr, wr_ptr, pq_rd, pq_wr;

  logic [31:0] buf_pc   [DEPTH];
  logic [31:0] buf_inst [DEPTH];
  logic [3:0]  buf_exc  [DEPTH];
  logic [31:0] pcq      [DEPTH];

  logic g_flush, adef, fault, credit, halted;
  logic issue, resp_drop, resp_live, bypass;
  logic empty, full, pop, push, fault_push;
  logic [31:0] push_pc, push_inst;
  logic [3:0]  push_exc;

  assign g_flush   = flush | ID_flush;
  assign adef      = |pc_q[1:0];
  assign fault     = adef | except_tlbr | except_pif | except_ppi;
  assign halted    = (state == ST_HALT);
  assign credit    = ((32'(out_cnt) + 32'(disc_cnt)) < MAX_OUTSTANDING) &&
                     ((32'(out_cnt) + 32'(occ)) < DEPTH);
  assign empty     = (occ == '0);
  assign full      = (occ == OW'(DEPTH));

  assign pc_vaddr       = pc_q;
  assign inst_sram_addr = pc_trans;
  assign inst_sram_en   = ~rst & credit & ~halted & ~fault & ~g_flush;
  assign issue          = inst_sram_en & inst_sram_addr_ok;

  // Responses are in order: pending discards are always older than any live request.
  assign resp_drop = inst_sram_data_ok & (disc_cnt != '0);
  assign resp_live = inst_sram_data_ok & (disc_cnt == '0) & (out_cnt != '0);

`ifdef IF_BYPASS_EN
  assign bypass = empty & resp_live & ID_allowin;
`else
  assign bypass = 1'b0;
`endif

  assign pop        = ~empty & ID_allowin;
  assign fault_push = fault & ~halted & ~g_flush & (out_cnt == '0) & (~full | ID_allowin);
  assign push       = (resp_live & ~bypass) | fault_push;
  assign IF_to_ID   = pop | bypass;

  assign disc_flush = disc_cnt + out_cnt + CW'(issue) - CW'(resp_drop | resp_live);

  always_comb begin
    push_pc   = pcq[pq_rd];
    push_inst = inst;
    push_exc  = '0;
    if (fault_push) begin
      push_pc   = pc_q;
      push_inst = '0;
      push_exc  = {adef, except_tlbr, except_pif, except_ppi};
    end
  end

  always_comb begin
    IF_to_ID_zip  = '0;
    IF_except_zip = '0;
    if (!empty) begin
      IF_to_ID_zip  = {~g_flush, buf_pc[rd_ptr], buf_inst[rd_ptr], 1'b0};
      IF_except_zip = buf_exc[rd_ptr];
    end else if (bypass) begin
      IF_to_ID_zip  = {~g_flush, pcq[pq_rd], inst, 1'b0};
    end
  end

  always_comb begin
    state_nxt = state;
    if (g_flush)         state_nxt = ST_RUN;
    else if (fault_push) state_nxt = ST_HALT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_RUN;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= PC_INIT;
      out_cnt  <= '0;
      disc_cnt <= '0;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pq_rd    <= '0;
      pq_wr    <= '0;
    end else if (g_flush) begin
      // Everything still in flight turns into a discard; buffer and PC queue restart empty.
      pc_q     <= flush ? flush_target : ID_flush_target;
      out_cnt  <= '0;
      disc_cnt <= disc_flush;
      occ      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      pq_rd    <= '0;
      pq_wr    <= '0;
    end else begin
      if (issue) begin
        pc_q  <= pc_q + 32'd4;
        pq_wr <= pq_wr + 1'b1;
      end
      out_cnt <= out_cnt + CW'(issue) - CW'(resp_live);
      if (resp_drop) disc_cnt <= disc_cnt - 1'b1;
      if (resp_live) pq_rd <= pq_rd + 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + OW'(push) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue) pcq[pq_wr] <= pc_q;
    if (push && !g_flush) begin
      buf_pc[wr_ptr]   <= push_pc;
      buf_inst[wr_ptr] <= push_inst;
      buf_exc[wr_ptr]  <= push_exc;
    end
  end

endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed bench for if_prefetch_queue: a small inst_sram responder, an expected-entry
// scoreboard filled on accepted requests and drained on transfers to ID.
module tb_if_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] MASK  = 32'h8000_0000;
`ifdef IF_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_vaddr, pc_trans, inst_sram_addr, inst, flush_target, ID_flush_target;
  logic        except_tlbr, except_pif, except_ppi;
  logic        inst_sram_en, inst_sram_addr_ok, inst_sram_data_ok;
  logic        flush, ID_flush, ID_allowin, IF_to_ID;
  logic [65:0] IF_to_ID_zip;
  logic [3:0]  IF_except_zip;

  always #5 clk = ~clk;
  assign pc_trans = pc_vaddr ^ MASK;

  if_prefetch_queue #(.DEPTH(DEPTH), .MAX_OUTSTANDING(2), .PC_INIT(32'h1c000000)) dut (
    .clk(clk), .rst(rst), .pc_vaddr(pc_vaddr), .pc_trans(pc_trans),
    .except_tlbr(except_tlbr), .except_pif(except_pif), .except_ppi(except_ppi),
    .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst(inst),
    .flush(flush), .flush_target(flush_target), .ID_flush(ID_flush),
    .ID_flush_target(ID_flush_target), .ID_allowin(ID_allowin), .IF_to_ID(IF_to_ID),
    .IF_to_ID_zip(IF_to_ID_zip), .IF_except_zip(IF_except_zip)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    logic [3:0]  exc;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    int          due;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int tests = 0, fails = 0, cyc = 0, pops = 0;
  logic [31:0] exp_pc;
  logic addr_ok_mode, resp_on, no_en;
  logic obs_en, obs_acc, obs_dok, obs_pop, obs_vpop;
  logic [31:0] obs_pc;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hdead_beef;
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    exp_t  e;
    resp_t r;
    inst_sram_data_ok = 1'b0;
    inst = '0;
    if (resp_on && resp_q.size() > 0 && resp_q[0].due <= cyc) begin
      inst_sram_data_ok = 1'b1;
      inst = mem_fn(resp_q[0].addr);
    end
    inst_sram_addr_ok = addr_ok_mode;
    #3;
    obs_en   = inst_sram_en;
    obs_acc  = inst_sram_en & inst_sram_addr_ok;
    obs_dok  = inst_sram_data_ok;
    obs_pop  = IF_to_ID;
    obs_vpop = IF_to_ID & IF_to_ID_zip[65];
    obs_pc   = IF_to_ID_zip[64:33];
    chk("pc_vaddr", 66'(pc_vaddr), 66'(exp_pc));
    if (inst_sram_en) begin
      chk("sram_addr", 66'(inst_sram_addr), 66'(exp_pc ^ MASK));
      chk("credit", 66'(exp_q.size() < DEPTH), 66'(1));
    end
    if (flush | ID_flush) chk("en_in_flush", 66'(inst_sram_en), 66'(0));
    if (no_en) chk("en_halted", 66'(inst_sram_en), 66'(0));
    if (IF_to_ID) begin
      pops++;
      if (flush | ID_flush) chk("flush_valid", 66'(IF_to_ID_zip[65]), 66'(0));
      else if (exp_q.size() == 0) chk("spurious_pop", 66'(1), 66'(0));
      else begin
        e = exp_q.pop_front();
        chk("zip", IF_to_ID_zip, {1'b1, e.pc, e.ins, 1'b0});
        chk("except", 66'(IF_except_zip), 66'(e.exc));
      end
    end
    if (inst_sram_data_ok) void'(resp_q.pop_front());
    if (obs_acc) begin
      r.addr = inst_sram_addr;
      r.due  = cyc + 1;
      resp_q.push_back(r);
      e.pc = exp_pc; e.ins = mem_fn(exp_pc ^ MASK); e.exc = 4'b0;
      exp_q.push_back(e);
      exp_pc = exp_pc + 32'd4;
    end
    if (flush) begin
      exp_pc = flush_target; exp_q.delete();
    end else if (ID_flush) begin
      exp_pc = ID_flush_target; exp_q.delete();
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_pop(input string tag, input logic [31:0] want);
    int n = 0;
    obs_vpop = 1'b0;
    while (!obs_vpop && n < 40) begin
      cycle();
      n++;
    end
    chk(tag, {33'b0, obs_vpop, obs_pc}, {33'b0, 1'b1, want});
  endtask

  task automatic push_fault(input logic [31:0] p, input logic [3:0] x);
    exp_t e;
    e.pc = p; e.ins = '0; e.exc = x;
    exp_q.push_back(e);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 0; ID_flush = 0; flush_target = '0; ID_flush_target = '0;
    except_tlbr = 0; except_pif = 0; except_ppi = 0; ID_allowin = 1;
    inst_sram_addr_ok = 0; inst_sram_data_ok = 0; inst = '0;
    addr_ok_mode = 1; resp_on = 1; no_en = 0; exp_pc = 32'h1c000000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 66'(inst_sram_en), 66'(0));
    chk("rst_if_to_id", 66'(IF_to_ID), 66'(0));
    chk("rst_zip", IF_to_ID_zip, 66'(0));
    chk("rst_except", 66'(IF_except_zip), 66'(0));
    chk("rst_pc", 66'(pc_vaddr), 66'(32'h1c000000));
    rst = 1'b0;

    // 1: streaming, one transfer per cycle after fill
    repeat (4) cycle();
    pops = 0;
    repeat (8) cycle();
    chk("stream_rate", 66'(pops), 66'(8));

    // 2: ID back-pressure fills buffer, then release in order
    ID_allowin = 0;
    repeat (10) cycle();
    chk("stall_en", 66'(obs_en), 66'(0));
    ID_allowin = 1;
    repeat (12) cycle();

    // 3: two outstanding, flush drops both responses
    resp_on = 0;
    repeat (4) cycle();
    chk("max_out_en", 66'(obs_en), 66'(0));
    flush = 1; flush_target = 32'h1c000100;
    cycle();
    flush = 0; resp_on = 1;
    wait_pop("flush_first_pc", 32'h1c000100);
    repeat (4) cycle();

    // 4: flush wins over ID_flush
    flush = 1; flush_target = 32'h1c000200; ID_flush = 1; ID_flush_target = 32'h1c000300;
    cycle();
    flush = 0; ID_flush = 0;
    wait_pop("flush_priority", 32'h1c000200);
    repeat (3) cycle();

    // 5: misaligned redirect -> adef entry, halted until next flush
    ID_flush = 1; ID_flush_target = 32'h1c000102;
    cycle();
    ID_flush = 0; no_en = 1;
    push_fault(32'h1c000102, 4'b1000);
    wait_pop("adef_entry", 32'h1c000102);
    pops = 0;
    repeat (6) cycle();
    chk("halted_no_pop", 66'(pops), 66'(0));
    except_pif = 1; flush = 1; flush_target = 32'h1c000400;
    cycle();
    flush = 0;
    push_fault(32'h1c000400, 4'b0010);
    wait_pop("pif_entry", 32'h1c000400);
    except_pif = 0;
    repeat (4) cycle();

    // 6: empty-buffer response latency to ID
    addr_ok_mode = 0; no_en = 0;
    flush = 1; flush_target = 32'h1c000500;
    cycle();
    flush = 0; addr_ok_mode = 1;
    cycle();
    chk("single_accept", 66'(obs_acc), 66'(1));
    addr_ok_mode = 0;
    for (int n = 0; n < 5 && !obs_dok; n++) cycle();
    chk("resp_seen", 66'(obs_dok), 66'(1));
    chk("bypass_same_cycle", 66'(obs_pop), 66'(BYP));
    cycle();
    chk("bypass_next_cycle", 66'(obs_pop), 66'(!BYP));

    // drain
    for (int n = 0; n < 30 && (exp_q.size() != 0 || resp_q.size() != 0); n++) cycle();
    chk("drained", 66'(exp_q.size()), 66'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
